vector_stream_ctrl: RTL and testbench

Sequencer that fills a `vector_reg_no_load` instance one scalar per cycle from a valid/ready input stream and presents the complete vector to a consumer. It then either releases the vector in place or drains it scalar-by-scalar onto a valid/ready output stream. It sits between the pixel/scalar streams and the LCMV vector datapath, owns the register's slice write and read ports, and drives its `write_index`, `slice_in`, `write_slice` and `read_index` pins directly.

---
 rtl/vector_stream_ctrl.sv | 116 +++++++++++
 tb/tb_vector_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_stream_ctrl.sv
// Fill/hold/drain sequencer for a vector_reg_no_load instance.
// Scalars are written one per accepted input beat. The complete vector is then
// held for an in-place consumer or streamed out scalar-by-scalar.
module vector_stream_ctrl #(
  parameter int unsigned SCALAR_BITS = 32,
  parameter int unsigned LENGTH      = 5,
  localparam int unsigned INDEX_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SCALAR_BITS-1:0] in_data,
  output logic [INDEX_WIDTH-1:0] reg_write_index,
  output logic [SCALAR_BITS-1:0] reg_slice_in,
  output logic                   reg_write_slice,
  output logic [INDEX_WIDTH-1:0] reg_read_index,
  input  logic [SCALAR_BITS-1:0] reg_slice_out,
  output logic                   vec_valid,
  input  logic                   vec_release,
  input  logic                   drain_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SCALAR_BITS-1:0] out_data,
  output logic                   out_last,
  input  logic                   flush
);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_FULL,
    ST_DRAIN
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LENGTH - 1);

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   in_fire;
  logic                   out_fire;
  logic                   idx_at_last;

  // Output decode from registered state/idx; rst and flush mask handshakes.
  always_comb begin
    idx_at_last     = (idx_q == LAST_IDX);
    in_ready        = (state_q == ST_FILL) && !rst && !flush;
    reg_write_slice = in_valid && in_ready;
    reg_write_index = rst ? '0 : idx_q;
    reg_slice_in    = in_data;
    reg_read_index  = rst ? '0 : idx_q;
    vec_valid       = (state_q == ST_FULL) && !rst;
    out_valid       = (state_q == ST_DRAIN) && !rst;
    out_last        = out_valid && idx_at_last;
    out_data        = reg_slice_out;
    in_fire         = reg_write_slice;
    out_fire        = out_valid && out_ready && !flush;
  end

  // Next state and shared index; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = ST_FILL;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_fire) begin
            if (idx_at_last) begin
              idx_d   = '0;
              state_d = ST_FULL;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (drain_start) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end else if (vec_release) begin
            state_d = ST_FILL;
            idx_d   = '0;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (idx_at_last) begin
              idx_d   = '0;
              state_d = ST_FILL;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_FILL;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State and index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_vector_stream_ctrl.sv
// Scoreboard bench for vector_stream_ctrl at LENGTH 5, 1 and 3 in parallel.
module tb_vector_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gb
    localparam int unsigned L  = (g == 0) ? 5 : (g == 1) ? 1 : 3;
    localparam int unsigned IW = (L > 1) ? $clog2(L) : 1;

    logic          rst         = 1'b1;
    logic          in_valid    = 1'b0;
    logic [31:0]   in_data     = '0;
    logic          vec_release = 1'b0;
    logic          drain_start = 1'b0;
    logic          out_ready   = 1'b0;
    logic          flush       = 1'b0;
    logic          in_ready, wr, vec_valid, out_valid, out_last;
    logic [IW-1:0] widx, ridx;
    logic [31:0]   slice_in, slice_out, out_data;
    logic [31:0]   mem [L];

    int unsigned   wq_i[$];
    logic [31:0]   wq_d[$];
    logic [31:0]   oq_d[$];
    logic          oq_l[$];
    bit            pat [7] = '{1, 0, 0, 1, 1, 1, 1};

    vector_stream_ctrl #(.SCALAR_BITS(32), .LENGTH(L)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .reg_write_index(widx), .reg_slice_in(slice_in), .reg_write_slice(wr),
      .reg_read_index(ridx), .reg_slice_out(slice_out),
      .vec_valid(vec_valid), .vec_release(vec_release), .drain_start(drain_start),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .flush(flush)
    );

    // Behavioural stand-in for the attached register.
    always @(posedge clk) if (wr && (32'(widx) < L)) mem[widx] <= slice_in;
    assign slice_out = (32'(ridx) < L) ? mem[ridx] : 32'hBAD0_BAD0;

    function automatic string nm(input string s);
      return $sformatf("L%0d %s", L, s);
    endfunction

    task automatic cyc();
      @(posedge clk);
      #1;
    endtask

    // Monitor: pops expected writes and output beats as the DUT presents them.
    always @(negedge clk) begin
      if (wr) begin
        if (wq_d.size() == 0) miss(nm("unexpected write"));
        else begin
          chk(nm("write index"), 32'(widx), wq_i[0]);
          chk(nm("write data"), slice_in, wq_d[0]);
          void'(wq_i.pop_front());
          void'(wq_d.pop_front());
        end
      end
      if (out_valid) begin
        if (oq_d.size() == 0) miss(nm("unexpected out_valid"));
        else begin
          chk(nm("out_data"), out_data, oq_d[0]);
          chk(nm("out_last"), 32'(out_last), 32'(oq_l[0]));
          if (out_ready) begin
            void'(oq_d.pop_front());
            void'(oq_l.pop_front());
          end
        end
      end
    end

    task automatic fill(input logic [31:0] base, input bit gap);
      for (int i = 0; i < int'(L); i++) begin
        wq_i.push_back(i);
        wq_d.push_back(base + 32'(i));
        in_valid = 1'b1;
        in_data  = base + 32'(i);
        @(negedge clk);
        chk(nm("in_ready fill"), 32'(in_ready), 1);
        chk(nm("vec_valid fill"), 32'(vec_valid), 0);
        cyc();
        if (gap) begin
          in_valid = 1'b0;
          in_data  = 32'hFFFF;
          cyc();
        end
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk(nm("vec_valid full"), 32'(vec_valid), 1);
      chk(nm("in_ready full"), 32'(in_ready), 0);
      cyc();
      in_valid = 1'b1;
      in_data  = 32'hEEEE;
      @(negedge clk);
      chk(nm("vec_valid hold"), 32'(vec_valid), 1);
      cyc();
      in_valid = 1'b0;
    endtask

    task automatic drain(input logic [31:0] base, input bit both);
      int k;
      for (int i = 0; i < int'(L); i++) begin
        oq_d.push_back(base + 32'(i));
        oq_l.push_back(i == int'(L) - 1);
      end
      drain_start = 1'b1;
      vec_release = both;
      cyc();
      drain_start = 1'b0;
      vec_release = 1'b0;
      k = 0;
      while (oq_d.size() != 0 && k < 40) begin
        out_ready = (k < 7) ? pat[k] : 1'b1;
        @(negedge clk);
        if (k == 0) begin
          chk(nm("out_valid first"), 32'(out_valid), 1);
          chk(nm("in_ready drain"), 32'(in_ready), 0);
          chk(nm("vec_valid drain"), 32'(vec_valid), 0);
        end
        cyc();
        k++;
      end
      if (oq_d.size() != 0) miss(nm("drain timeout"));
      out_ready = 1'b0;
      @(negedge clk);
      chk(nm("in_ready after last"), 32'(in_ready), 1);
      chk(nm("out_valid after last"), 32'(out_valid), 0);
      cyc();
    endtask

    initial begin
      int n, r;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(nm("rst in_ready"), 32'(in_ready), 0);
      chk(nm("rst write"), 32'(wr), 0);
      chk(nm("rst vec_valid"), 32'(vec_valid), 0);
      chk(nm("rst out_valid"), 32'(out_valid), 0);
      chk(nm("rst out_last"), 32'(out_last), 0);
      chk(nm("rst widx"), 32'(widx), 0);
      chk(nm("rst ridx"), 32'(ridx), 0);
      cyc();
      rst      = 1'b0;
      in_valid = 1'b0;

      fill(32'd10, 1'b0);
      drain(32'd10, 1'b0);
      fill(32'd10, 1'b1);
      drain(32'd10, 1'b1);

      n = (L > 3) ? 3 : int'(L) - 1;
      for (int i = 0; i < n; i++) begin
        wq_i.push_back(i);
        wq_d.push_back(32'd90 + 32'(i));
        in_valid = 1'b1;
        in_data  = 32'd90 + 32'(i);
        cyc();
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'd99;
      @(negedge clk);
      chk(nm("flush in_ready"), 32'(in_ready), 0);
      chk(nm("flush write"), 32'(wr), 0);
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      fill(32'd20, 1'b0);
      drain(32'd20, 1'b0);

      r = (L > 2) ? 2 : int'(L) - 1;
      fill(32'd30, 1'b0);
      for (int i = 0; i < r; i++) begin
        oq_d.push_back(32'd30 + 32'(i));
        oq_l.push_back(1'b0);
      end
      drain_start = 1'b1;
      cyc();
      drain_start = 1'b0;
      out_ready   = 1'b1;
      for (int i = 0; i < r; i++) cyc();
      rst = 1'b1;
      @(negedge clk);
      chk(nm("mid rst out_valid"), 32'(out_valid), 0);
      chk(nm("mid rst in_ready"), 32'(in_ready), 0);
      chk(nm("mid rst ridx"), 32'(ridx), 0);
      cyc();
      rst       = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk(nm("post rst in_ready"), 32'(in_ready), 1);
      chk(nm("post rst out_valid"), 32'(out_valid), 0);
      chk(nm("post rst widx"), 32'(widx), 0);
      cyc();
      fill(32'd40, 1'b0);
      drain(32'd40, 1'b0);

      fill(32'd50, 1'b0);
      vec_release = 1'b1;
      cyc();
      vec_release = 1'b0;
      @(negedge clk);
      chk(nm("release in_ready"), 32'(in_ready), 1);
      chk(nm("release vec_valid"), 32'(vec_valid), 0);
      cyc();
      fill(32'd60, 1'b0);
      drain(32'd60, 1'b0);

      chk(nm("write queue drained"), 32'(wq_d.size()), 0);
      chk(nm("beat queue drained"), 32'(oq_d.size()), 0);
      done_cnt++;
    end
  end

  initial begin
    int cycles = 0;
    while (done_cnt < 3 && cycles < 20000) begin
      @(posedge clk);
      cycles++;
    end
    if (done_cnt < 3) miss("global timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
